// File: rtl/icache_pkg.sv
// Shared configuration for the instruction cache: default geometry and trace switches.
package icache_pkg;

    localparam int ICACHE_LINE_BITS = 5;
    localparam bit ICACHE_DEBUG     = 1'b0;
    localparam bit ICACHE_HEAD      = 1'b0;

endpackage

// File: rtl/icache_if.sv
// Fetch-side and memory-side signal bundle of the instruction cache.
interface icache_if;

    logic        fetch_enable;
    logic [31:0] fetch_addr;
    logic        fetch_clear;
    logic        fetch_valid;
    logic [31:0] fetch_instr;
    logic        mem_enable;
    logic [31:0] mem_addr;
    logic        mem_valid;
    logic [31:0] mem_instr;

    modport slave (
        input  fetch_enable, fetch_addr, fetch_clear, mem_valid, mem_instr,
        output fetch_valid, fetch_instr, mem_enable, mem_addr
    );

    modport master (
        output fetch_enable, fetch_addr, fetch_clear, mem_valid, mem_instr,
        input  fetch_valid, fetch_instr, mem_enable, mem_addr
    );

endinterface

// File: rtl/icache.sv
// Direct-mapped one-word-per-line instruction cache with a single outstanding miss.
// state | meaning
// IDLE  | accepts requests; hits answered next cycle, misses start a memory read
// MISS  | memory read outstanding; mem_enable/mem_addr held until mem_valid
// DONE  | one bubble after a fill so the memory controller returns to idle
module icache
    import icache_pkg::*;
#(
    parameter int LINE_BITS = ICACHE_LINE_BITS
) (
    input  logic     clk,
    input  logic     rst,
    input  logic     rdy,
    icache_if.slave  bus
);

    localparam int LINES = 1 << LINE_BITS;
    localparam int TAG_W = 30 - LINE_BITS;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MISS = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic                 fetch_valid_q, fetch_valid_d;
    logic [31:0]          fetch_instr_q, fetch_instr_d;
    logic                 mem_enable_q, mem_enable_d;
    logic [31:0]          mem_addr_q, mem_addr_d;
    logic                 cancel_q, cancel_d;
    logic [LINE_BITS-1:0] req_idx_q, req_idx_d;
    logic [TAG_W-1:0]     req_tag_q, req_tag_d;

    logic [LINES-1:0]     valid_q;
    logic [TAG_W-1:0]     tag_q  [LINES];
    logic [31:0]          data_q [LINES];

    logic [LINE_BITS-1:0] fetch_idx;
    logic [TAG_W-1:0]     fetch_tag;
    logic                 hit;
    logic                 fill_we;

    assign fetch_idx = bus.fetch_addr[LINE_BITS+1:2];
    assign fetch_tag = bus.fetch_addr[31:LINE_BITS+2];
    assign hit       = valid_q[fetch_idx] && (tag_q[fetch_idx] == fetch_tag);
    assign fill_we   = rdy && (state_q == S_MISS) && bus.mem_valid;

    always_comb begin
        state_d       = state_q;
        fetch_valid_d = fetch_valid_q;
        fetch_instr_d = fetch_instr_q;
        mem_enable_d  = mem_enable_q;
        mem_addr_d    = mem_addr_q;
        cancel_d      = cancel_q;
        req_idx_d     = req_idx_q;
        req_tag_d     = req_tag_q;
        if (rdy) begin
            fetch_valid_d = 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    if (bus.fetch_enable && !bus.fetch_clear) begin
                        if (hit) begin
                            fetch_valid_d = 1'b1;
                            fetch_instr_d = data_q[fetch_idx];
                        end else begin
                            mem_enable_d = 1'b1;
                            mem_addr_d   = bus.fetch_addr & 32'hFFFF_FFFC;
                            req_idx_d    = fetch_idx;
                            req_tag_d    = fetch_tag;
                            cancel_d     = 1'b0;
                            state_d      = S_MISS;
                        end
                    end
                end
                S_MISS: begin
                    if (bus.fetch_clear) begin
                        cancel_d = 1'b1;
                    end
                    if (bus.mem_valid) begin
                        mem_enable_d = 1'b0;
                        cancel_d     = 1'b0;
                        state_d      = S_DONE;
                        // A clear on the very cycle the data arrives still cancels delivery.
                        if (!(cancel_q || bus.fetch_clear)) begin
                            fetch_valid_d = 1'b1;
                            fetch_instr_d = bus.mem_instr;
                        end
                    end
                end
                S_DONE: begin
                    state_d = S_IDLE;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            fetch_valid_q <= 1'b0;
            fetch_instr_q <= '0;
            mem_enable_q  <= 1'b0;
            mem_addr_q    <= '0;
            cancel_q      <= 1'b0;
            req_idx_q     <= '0;
            req_tag_q     <= '0;
            valid_q       <= '0;
        end else begin
            state_q       <= state_d;
            fetch_valid_q <= fetch_valid_d;
            fetch_instr_q <= fetch_instr_d;
            mem_enable_q  <= mem_enable_d;
            mem_addr_q    <= mem_addr_d;
            cancel_q      <= cancel_d;
            req_idx_q     <= req_idx_d;
            req_tag_q     <= req_tag_d;
            if (fill_we) begin
                valid_q[req_idx_q] <= 1'b1;
            end
        end
    end

    // Tag/data need no reset: a line is only trusted once its valid bit is set.
    always_ff @(posedge clk) begin
        if (fill_we) begin
            tag_q[req_idx_q]  <= req_tag_q;
            data_q[req_idx_q] <= bus.mem_instr;
        end
    end

    assign bus.fetch_valid = fetch_valid_q;
    assign bus.fetch_instr = fetch_instr_q;
    assign bus.mem_enable  = mem_enable_q;
    assign bus.mem_addr    = mem_addr_q;

endmodule

// File: doc/icache.md
ICACHE -- requirements
Module: icache

Interface
REQ-001 Parameter: LINE_BITS, 5, log2 of line count; 2^LINE_BITS direct-mapped lines, one 32-bit word each.
REQ-002 clk  input  1  single clock; all state updates on posedge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 rdy  input  1  global enable; when 0 all state and outputs hold.
REQ-005 fetch_enable  input  1  fetch requests instruction at fetch_addr.
REQ-006 fetch_addr  input  32  byte address, word aligned; bits [1:0] ignored.
REQ-007 fetch_clear  input  1  flush pending request (branch mispredict); cache contents kept.
REQ-008 fetch_valid  output  1  one-cycle pulse: fetch_instr valid for current request.
REQ-009 fetch_instr  output  32  instruction word.
REQ-010 mem_enable  output  1  level request to memory controller instruction port.
REQ-011 mem_addr  output  32  word address sent to memory controller.
REQ-012 mem_valid  input  1  one-cycle pulse from memory controller: mem_instr valid.
REQ-013 mem_instr  input  32  fetched word, little-endian assembled.

Function
REQ-014 Address split: index = addr[LINE_BITS+1:2], tag = addr[31:LINE_BITS+2]; per line store valid bit, tag, 32-bit data.
REQ-015 States IDLE, MISS, DONE; only IDLE accepts requests.
REQ-016 IDLE, fetch_enable=1, fetch_clear=0, hit (valid && tag match): next cycle fetch_valid=1, fetch_instr=line data, state stays IDLE; hit latency exactly 1 cycle.
REQ-017 IDLE, fetch_enable=1, fetch_clear=0, miss: next cycle mem_enable=1, mem_addr={fetch_addr[31:2],2'b00}, state MISS; request tag/index latched.
REQ-018 MISS: mem_enable and mem_addr held constant until mem_valid sampled.
REQ-019 MISS, mem_valid=1: next cycle line written (valid=1, latched tag, mem_instr), mem_enable=0, fetch_valid=1 with fetch_instr=mem_instr unless request cancelled, state DONE.
REQ-020 DONE: one bubble cycle, fetch_valid=0, mem_enable=0, requests ignored, then IDLE; guarantees memory controller returns to idle before next request.
REQ-021 fetch_valid is 0 in every cycle not named in REQ-016/REQ-019.
REQ-022 fetch_clear in IDLE: any request that cycle ignored, no output next cycle.
REQ-023 fetch_clear in MISS (any cycle incl. the mem_valid cycle): request marked cancelled; memory transaction not aborted; fill still written; fetch_valid suppressed.
REQ-024 fetch_enable during MISS/DONE ignored; fetch re-asserts until fetch_valid seen.
REQ-025 Fill and a same-index later request: later request sees new line (write precedes DONE→IDLE).
REQ-026 rdy=0 in any state: no transition, no fill, outputs hold; mem_valid pulses are only delivered while rdy=1 (controller also gated).

Reset
REQ-027 rst=1 at clock edge: all line valid bits 0, state IDLE, fetch_valid=0, fetch_instr=0, mem_enable=0, mem_addr=0, cancel flag 0.
REQ-028 Reset mid-MISS drops the transaction; no fill, no fetch_valid afterwards; tag/data arrays need not be cleared.
REQ-029 Reset has priority over rdy.

Structure
REQ-030 Shared config header holds LINE_BITS default and DEBUG/HEAD trace switches; state encodings local to icache.
REQ-031 No sub-module; arrays as register arrays inside icache.

Verification
REQ-032 Cold miss: fetch 0x0000_0010, memory returns 0x0000_0513 after 5 cycles -> mem_addr=0x10 held through MISS, fetch_valid once with 0x0000_0513, mem_enable low next cycle.
REQ-033 Hit: repeat fetch 0x10 after DONE -> fetch_valid next cycle, 0x0000_0513, mem_enable stays 0.
REQ-034 Conflict: fetch 0x10 then 0x90 (LINE_BITS=5, same index, different tag) -> second misses, line replaced; refetch 0x10 misses again.
REQ-035 Clear: fetch 0x20 miss, fetch_clear pulsed during MISS -> no fetch_valid; subsequent fetch 0x20 hits with filled data.
REQ-036 rdy low 3 cycles during MISS and during hit response -> outputs frozen, timing shifted by exactly 3 cycles.
REQ-037 Reset mid-MISS then fetch 0x10 -> miss (valid bits cleared), new memory request issued.
